status_flag_ctrl: RTL and testbench

//  Owns the architectural NZCV status register and sequences flag updates through EXE->MEM->commit.

---
 rtl/arm_cond_pkg.sv | 27 ++
 rtl/flag_stage_reg.sv | 25 ++
 rtl/status_flag_ctrl.sv | 98 +++++++++
 tb/tb_status_flag_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/arm_cond_pkg.sv
// ARM condition-code encodings and NZCV flag bit positions, shared by the status flag
// control logic and its pipeline stage registers.
package arm_cond_pkg;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/flag_stage_reg.sv
// One pipeline slot of in-flight flag state: a valid bit plus NZCV.
// Holds while en is low; synchronous active-low reset clears both fields.
module flag_stage_reg
  import arm_cond_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       valid_d,
  input  logic [3:0] flags_d,
  output logic       valid_q,
  output logic [3:0] flags_q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      flags_q <= 4'b0000;
    end else if (en) begin
      valid_q <= valid_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: rtl/status_flag_ctrl.sv
// NZCV status register with EXE->MEM->commit sequencing and ID flag-hazard stall.
// Define FLAG_FWD_EN to forward in-flight flags to ID instead of stalling.
module status_flag_ctrl
  import arm_cond_pkg::*;
#(
  parameter int         CNT_W   = 16,
  parameter logic [3:0] COND_AL = CC_AL,
  parameter logic [3:0] COND_NV = CC_NV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_cond,
  input  logic             id_s,
  input  logic [3:0]       exe_flags,
  input  logic             flush,
  input  logic             freeze,
  output logic [3:0]       status_bits,
  output logic             stall_id,
  output logic [3:0]       flags_arch,
  output logic [1:0]       pending,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic inc);
    if (inc && (cnt != '1)) return cnt + CNT_ONE;
    return cnt;
  endfunction

  logic             needs_flags;
  logic             hazard;
  logic             stall_int;
  logic             p_exe_d;
  logic             p_exe_q;
  logic             p_mem_q;
  logic [3:0]       f_mem_q;
  logic [3:0]       exe_slot_flags_unused;
  logic [3:0]       flags_arch_d;
  logic [3:0]       flags_arch_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  always_comb begin
    needs_flags = id_valid & (id_cond != COND_AL) & (id_cond != COND_NV);
    hazard      = needs_flags & (p_exe_q | p_mem_q);
`ifdef FLAG_FWD_EN
    stall_int   = 1'b0;
    status_bits = p_exe_q ? exe_flags : (p_mem_q ? f_mem_q : flags_arch_q);
`else
    stall_int   = hazard & ~flush;
    status_bits = flags_arch_q;
`endif
    // A stalled or flushed flag-setter becomes a bubble in EXE
    p_exe_d      = id_valid & id_s & ~stall_int & ~flush;
    flags_arch_d = p_mem_q ? f_mem_q : flags_arch_q;
    stall_cnt_d  = sat_inc(stall_cnt_q, stall_int);
  end

  // EXE slot tracks only the writer; its flags appear on exe_flags directly
  flag_stage_reg u_exe_stage (
    .clk     (clk),
    .rst     (rst),
    .en      (~freeze),
    .valid_d (p_exe_d),
    .flags_d (4'b0000),
    .valid_q (p_exe_q),
    .flags_q (exe_slot_flags_unused)
  );

  flag_stage_reg u_mem_stage (
    .clk     (clk),
    .rst     (rst),
    .en      (~freeze),
    .valid_d (p_exe_q),
    .flags_d (exe_flags),
    .valid_q (p_mem_q),
    .flags_q (f_mem_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_arch_q <= 4'b0000;
      stall_cnt_q  <= '0;
    end else if (!freeze) begin
      flags_arch_q <= flags_arch_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stall_id   = stall_int;
  assign flags_arch = flags_arch_q;
  assign pending    = {p_mem_q, p_exe_q};
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_status_flag_ctrl.sv
// Scoreboard bench for status_flag_ctrl (default build): directed per-cycle vectors push
// expected outputs; a negedge monitor pops and compares. A CNT_W=2 copy checks saturation.
module tb_status_flag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic [3:0]  id_cond = 4'h0;
  logic        id_s = 1'b0;
  logic [3:0]  exe_flags = 4'h0;
  logic        flush = 1'b0;
  logic        freeze = 1'b0;

  logic [3:0]  status_bits, flags_arch;
  logic        stall_id;
  logic [1:0]  pending;
  logic [15:0] stall_cnt;

  logic [3:0]  status_bits2, flags_arch2;
  logic        stall_id2;
  logic [1:0]  pending2;
  logic [1:0]  stall_cnt2;

  status_flag_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond), .id_s(id_s),
    .exe_flags(exe_flags), .flush(flush), .freeze(freeze),
    .status_bits(status_bits), .stall_id(stall_id), .flags_arch(flags_arch),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  status_flag_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond), .id_s(id_s),
    .exe_flags(exe_flags), .flush(flush), .freeze(freeze),
    .status_bits(status_bits2), .stall_id(stall_id2), .flags_arch(flags_arch2),
    .pending(pending2), .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        chk;
    logic        stall;
    logic [1:0]  pend;
    logic [3:0]  arch;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   step_no = 0;

  task automatic cmp(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp("stall_id", e.idx, {15'd0, stall_id}, {15'd0, e.stall});
      cmp("stall_id_sat", e.idx, {15'd0, stall_id2}, {15'd0, e.stall});
      if (e.chk) begin
        cmp("pending", e.idx, {14'd0, pending}, {14'd0, e.pend});
        cmp("flags_arch", e.idx, {12'd0, flags_arch}, {12'd0, e.arch});
        cmp("status_bits", e.idx, {12'd0, status_bits}, {12'd0, e.arch});
        cmp("stall_cnt", e.idx, stall_cnt, e.cnt);
        cmp("stall_cnt_sat", e.idx, {14'd0, stall_cnt2}, {14'd0, e.cnt2});
      end
    end
  end

  // Inputs for one cycle plus the outputs expected during that cycle.
  task automatic step(input logic r, input logic v, input logic [3:0] c, input logic s,
                      input logic [3:0] ex, input logic fl, input logic fz,
                      input logic ck, input logic st, input logic [1:0] pd,
                      input logic [3:0] ar, input logic [15:0] cn, input logic [1:0] cn2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_cond = c; id_s = s;
    exe_flags = ex; flush = fl; freeze = fz;
    e.idx = step_no; e.chk = ck; e.stall = st; e.pend = pd;
    e.arch = ar; e.cnt = cn; e.cnt2 = cn2;
    sb.push_back(e);
    step_no++;
  endtask

  initial begin
    // reset
    step(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 2'd0, 4'h0, 16'd0, 2'd0);
    step(0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 2'd0, 4'h0, 16'd0, 2'd0);
    // CMP then EQ dependent: two stall cycles, commit 0100
    step(1, 1, 4'hE, 1, 4'h0, 0, 0, 1, 0, 2'd0, 4'h0, 16'd0, 2'd0);
    step(1, 1, 4'h0, 0, 4'h4, 0, 0, 1, 1, 2'd1, 4'h0, 16'd0, 2'd0);
    step(1, 1, 4'h0, 0, 4'hF, 0, 0, 1, 1, 2'd2, 4'h0, 16'd1, 2'd1);
    step(1, 1, 4'h0, 0, 4'h0, 0, 0, 1, 0, 2'd0, 4'h4, 16'd2, 2'd2);
    // AL behind a flag-setter never stalls
    step(1, 1, 4'hE, 1, 4'h0, 0, 0, 1, 0, 2'd0, 4'h4, 16'd2, 2'd2);
    step(1, 1, 4'hE, 0, 4'h2, 0, 0, 1, 0, 2'd1, 4'h4, 16'd2, 2'd2);
    step(1, 1, 4'hE, 0, 4'h0, 0, 0, 1, 0, 2'd2, 4'h4, 16'd2, 2'd2);
    step(1, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 2'd0, 4'h2, 16'd2, 2'd2);
    // freeze with p_exe set: everything holds, stall_id still driven
    step(1, 1, 4'hE, 1, 4'h0, 0, 0, 1, 0, 2'd0, 4'h2, 16'd2, 2'd2);
    step(1, 1, 4'h0, 0, 4'h8, 0, 1, 1, 1, 2'd1, 4'h2, 16'd2, 2'd2);
    step(1, 1, 4'h0, 0, 4'h8, 0, 1, 1, 1, 2'd1, 4'h2, 16'd2, 2'd2);
    step(1, 1, 4'h0, 0, 4'h8, 0, 1, 1, 1, 2'd1, 4'h2, 16'd2, 2'd2);
    step(1, 1, 4'h0, 0, 4'h8, 0, 0, 1, 1, 2'd1, 4'h2, 16'd2, 2'd2);
    step(1, 1, 4'h0, 0, 4'h0, 0, 0, 1, 1, 2'd2, 4'h2, 16'd3, 2'd3);
    step(1, 1, 4'h0, 0, 4'h0, 0, 0, 1, 0, 2'd0, 4'h8, 16'd4, 2'd3);
    // flush with dependent in ID: no stall, S instruction killed
    step(1, 1, 4'hE, 1, 4'h0, 0, 0, 1, 0, 2'd0, 4'h8, 16'd4, 2'd3);
    step(1, 1, 4'h0, 1, 4'h6, 1, 0, 1, 0, 2'd1, 4'h8, 16'd4, 2'd3);
    step(1, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 2'd2, 4'h8, 16'd4, 2'd3);
    step(1, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 2'd0, 4'h6, 16'd4, 2'd3);
    // back-to-back writers commit in order, later wins
    step(1, 1, 4'hE, 1, 4'h0, 0, 0, 1, 0, 2'd0, 4'h6, 16'd4, 2'd3);
    step(1, 1, 4'hE, 1, 4'h1, 0, 0, 1, 0, 2'd1, 4'h6, 16'd4, 2'd3);
    step(1, 1, 4'h0, 0, 4'h3, 0, 0, 1, 1, 2'd3, 4'h6, 16'd4, 2'd3);
    step(1, 1, 4'h0, 0, 4'h0, 0, 0, 1, 1, 2'd2, 4'h1, 16'd5, 2'd3);
    step(1, 1, 4'h0, 0, 4'h0, 0, 0, 1, 0, 2'd0, 4'h3, 16'd6, 2'd3);
    // reset mid-stall discards in-flight flags
    step(1, 1, 4'hE, 1, 4'h0, 0, 0, 1, 0, 2'd0, 4'h3, 16'd6, 2'd3);
    step(0, 1, 4'h0, 0, 4'h5, 0, 0, 1, 1, 2'd1, 4'h3, 16'd6, 2'd3);
    step(1, 1, 4'h0, 0, 4'h5, 0, 0, 1, 0, 2'd0, 4'h0, 16'd0, 2'd0);
    step(1, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 2'd0, 4'h0, 16'd0, 2'd0);
    // NV has no dependency; NE does
    step(1, 1, 4'hE, 1, 4'h0, 0, 0, 1, 0, 2'd0, 4'h0, 16'd0, 2'd0);
    step(1, 1, 4'hF, 0, 4'h0, 0, 0, 1, 0, 2'd1, 4'h0, 16'd0, 2'd0);
    step(1, 1, 4'h1, 0, 4'h0, 0, 0, 1, 1, 2'd2, 4'h0, 16'd0, 2'd0);
    step(1, 1, 4'h1, 0, 4'h0, 0, 0, 1, 0, 2'd0, 4'h0, 16'd1, 2'd1);
    step(1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 2'd0, 4'h0, 16'd0, 2'd0);

    repeat (4) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
